// File: rtl/sha256_mem_host.sv
// sha256_mem_host
// Host-side controller for a shared-memory SHA-256 engine. A message arrives
// as a valid/ready stream of 32-bit words and is written into word-addressed
// RAM at INPUT_ADDR. The engine is then started and the host waits for its
// done level to fall and rise again. The 8 hash words are read back from
// HASH_ADDR and streamed out, H0 first.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   msg_valid/msg_data   message word stream in; msg_ready = host accepts
//   hash_valid/hash_data hash word stream out; hash_last marks the 8th word,
//   hash_ready           sink handshake
//   sha_start            one-cycle start pulse to the engine
//   sha_input_addr       constant INPUT_ADDR for the engine
//   sha_hash_addr        constant HASH_ADDR for the engine
//   sha_done             engine done level (high while engine idle)
//   mem_sel              1 = engine owns the RAM port, 0 = host owns it
//   mem_we/mem_addr/     host RAM write port
//   mem_write_data
//   mem_read_data        RAM read data, one cycle after the address
//   busy                 controller not idle
//   error                engine timed out; cleared by clear
//   clear                leaves ERROR, ignored in every other state

module sha256_mem_host #(
    parameter int unsigned NUM_OF_WORDS   = 40,
    parameter logic [15:0] INPUT_ADDR     = 16'h0000,
    parameter logic [15:0] HASH_ADDR      = 16'h0100,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    output logic        msg_ready,
    output logic        hash_valid,
    output logic [31:0] hash_data,
    output logic        hash_last,
    input  logic        hash_ready,
    output logic        sha_start,
    output logic [15:0] sha_input_addr,
    output logic [15:0] sha_hash_addr,
    input  logic        sha_done,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy,
    output logic        error,
    input  logic        clear
);

    localparam int CNT_W = $clog2(NUM_OF_WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_OF_WORDS - 1);
    // The wait ends on the cycle where tmo would step to TIMEOUT_CYCLES, so
    // exactly TIMEOUT_CYCLES cycles are spent in WAIT_LOW plus WAIT_HIGH.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_FETCH,
        S_OUT,
        S_ERROR
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [TMO_W-1:0] tmo, tmo_next;
    logic [3:0]       fetch_cnt, fetch_cnt_next;
    logic [2:0]       idx, idx_next;
    logic [31:0]      hash_buf [8];

    assign sha_input_addr = INPUT_ADDR;
    assign sha_hash_addr  = HASH_ADDR;
    assign busy           = (state != S_IDLE);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tmo       <= '0;
            fetch_cnt <= '0;
            idx       <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            tmo       <= tmo_next;
            fetch_cnt <= fetch_cnt_next;
            idx       <= idx_next;
        end
    end

    // FETCH cycle k (1..8) sees the read data for the address driven in
    // cycle k-1, so it lands in slot k-1.
    // NOTE: the hash buffer is plain storage with no reset; it is always
    // rewritten before OUT reads it, and hash_data is forced to 0 outside OUT.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && fetch_cnt != 4'd0) begin
            hash_buf[3'(fetch_cnt - 4'd1)] <= mem_read_data;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        tmo_next       = tmo;
        fetch_cnt_next = fetch_cnt;
        idx_next       = idx;
        msg_ready      = 1'b0;
        hash_valid     = 1'b0;
        hash_data      = 32'h0;
        hash_last      = 1'b0;
        sha_start      = 1'b0;
        mem_sel        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0;
        mem_write_data = 32'h0;
        error          = 1'b0;

        case (state)
            S_IDLE, S_LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    // The write goes out in the accepting cycle itself.
                    mem_we         = 1'b1;
                    mem_addr       = INPUT_ADDR + 16'(cnt);
                    mem_write_data = msg_data;
                    if (cnt == LAST_WORD) begin
                        state_next = S_START;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_LOAD;
                        cnt_next   = cnt + 1'b1;
                    end
                end
            end

            S_START: begin
                sha_start  = 1'b1;
                mem_sel    = 1'b1;
                tmo_next   = '0;
                state_next = S_WAIT_LOW;
            end

            // done is still high from the idle engine when we get here;
            // only its fall proves the engine picked up the start pulse.
            S_WAIT_LOW: begin
                mem_sel  = 1'b1;
                tmo_next = tmo + 1'b1;
                if (!sha_done) begin
                    state_next = S_WAIT_HIGH;
                end else if (tmo >= TMO_LAST) begin
                    state_next = S_ERROR;
                end
            end

            // done is tested before the timeout, so a finish on the last
            // allowed cycle still counts as success.
            S_WAIT_HIGH: begin
                mem_sel  = 1'b1;
                tmo_next = tmo + 1'b1;
                if (sha_done) begin
                    state_next     = S_FETCH;
                    fetch_cnt_next = '0;
                end else if (tmo >= TMO_LAST) begin
                    state_next = S_ERROR;
                end
            end

            S_FETCH: begin
                if (!fetch_cnt[3]) begin
                    mem_addr = HASH_ADDR + 16'(fetch_cnt);
                end
                if (fetch_cnt == 4'd8) begin
                    state_next     = S_OUT;
                    fetch_cnt_next = '0;
                    idx_next       = '0;
                end else begin
                    fetch_cnt_next = fetch_cnt + 4'd1;
                end
            end

            S_OUT: begin
                hash_valid = 1'b1;
                hash_data  = hash_buf[idx];
                hash_last  = (idx == 3'd7);
                if (hash_ready) begin
                    idx_next = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_ERROR: begin
                error = 1'b1;
                if (clear) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    tmo_next   = '0;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule
